prim_count_bank: RTL and testbench

- Multi-channel hardened cross counter bank.
- Each channel keeps a primary up-counter and a secondary down-counter; their sum must stay at 2**Width-1.
- Adds two things to the single hardened counter:
  - per-bank saturate or wrap mode, with a wrap event pulse;
  - per-channel threshold-crossing pulse and sticky integrity error.
- Used by timer/event-counter IPs that need several protected counters behind one alert source.

---
 rtl/prim_count_bank_pkg.sv | 19 +
 rtl/prim_count_bank_chan.sv | 114 +++++++++++
 rtl/prim_count_bank.sv | 73 +++++++
 tb/tb_prim_count_bank.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/prim_count_bank_pkg.sv
// Shared types for the hardened cross-counter bank: counting mode and
// the per-channel action mask used to strip unused update paths.
package prim_count_bank_pkg;

    typedef enum logic {
        CntSaturate = 1'b0,
        CntWrap     = 1'b1
    } count_mode_e;

    typedef struct packed {
        logic clr;
        logic set;
        logic incr;
        logic decr;
    } action_mask_t;

    localparam action_mask_t ActionsAll = '{clr: 1'b1, set: 1'b1, incr: 1'b1, decr: 1'b1};

endpackage

// File: rtl/prim_count_bank_chan.sv
// One hardened channel: primary up-counter plus secondary down-counter whose
// sum must stay all-ones, with saturate/wrap handling, pulses and error flop.
module prim_count_bank_chan
    import prim_count_bank_pkg::*;
#(
    parameter int unsigned        Width           = 8,
    parameter logic [Width-1:0]   ResetValue      = '0,
    parameter count_mode_e        Mode            = CntSaturate,
    parameter bit                 ErrSticky       = 1'b1,
    parameter action_mask_t       PossibleActions = ActionsAll
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             set_i,
    input  logic [Width-1:0] set_cnt_i,
    input  logic             incr_en_i,
    input  logic             decr_en_i,
    input  logic [Width-1:0] step_i,
    input  logic             commit_i,
    input  logic [Width-1:0] thresh_i,
    output logic [Width-1:0] cnt_o,
    output logic [Width-1:0] cnt_after_commit_o,
    output logic             thresh_hit_o,
    output logic             wrap_o,
    output logic             err_o,
    output logic             err_nxt_o
);

    localparam logic [Width-1:0] MaxVal = '1;

    logic [Width-1:0] prim_q, prim_d, sec_q, sec_d;
    logic             hit_q, hit_d, wrap_q, wrap_d, err_q, err_d;

    logic             clr_act, set_act, up, dn;
    logic [Width:0]   prim_up, prim_dn, sec_up, sec_dn;
    logic [Width-1:0] prim_nxt, sec_nxt;
    logic             wrap_nxt, err_cmp;

    always_comb begin
        clr_act  = clr_i & PossibleActions.clr;
        set_act  = set_i & PossibleActions.set;
        up       = (incr_en_i & PossibleActions.incr) & ~(decr_en_i & PossibleActions.decr);
        dn       = (decr_en_i & PossibleActions.decr) & ~(incr_en_i & PossibleActions.incr);
        prim_up  = {1'b0, prim_q} + {1'b0, step_i};
        prim_dn  = {1'b0, prim_q} - {1'b0, step_i};
        sec_up   = {1'b0, sec_q} + {1'b0, step_i};
        sec_dn   = {1'b0, sec_q} - {1'b0, step_i};
        prim_nxt = prim_q;
        sec_nxt  = sec_q;
        wrap_nxt = 1'b0;

        // The secondary is updated from its own flop, never derived from the
        // primary, so a corrupted half stays visible to the sum check.
        if (clr_act) begin
            prim_nxt = ResetValue;
            sec_nxt  = MaxVal - ResetValue;
        end else if (set_act) begin
            prim_nxt = set_cnt_i;
            sec_nxt  = MaxVal - set_cnt_i;
        end else if (step_i != '0) begin
            if (up) begin
                if (prim_up[Width] && (Mode == CntSaturate)) begin
                    prim_nxt = MaxVal;
                    sec_nxt  = '0;
                end else begin
                    prim_nxt = prim_up[Width-1:0];
                    sec_nxt  = sec_dn[Width-1:0];
                    wrap_nxt = prim_up[Width];
                end
            end else if (dn) begin
                if (prim_dn[Width] && (Mode == CntSaturate)) begin
                    prim_nxt = '0;
                    sec_nxt  = MaxVal;
                end else begin
                    prim_nxt = prim_dn[Width-1:0];
                    sec_nxt  = sec_up[Width-1:0];
                    wrap_nxt = prim_dn[Width];
                end
            end
        end

        prim_d  = commit_i ? prim_nxt : prim_q;
        sec_d   = commit_i ? sec_nxt : sec_q;
        wrap_d  = commit_i & wrap_nxt;
        hit_d   = commit_i & (prim_q < thresh_i) & (prim_nxt >= thresh_i);
        err_cmp = ({1'b0, prim_q} + {1'b0, sec_q}) != {1'b0, MaxVal};
        err_d   = ErrSticky ? (err_cmp | err_q) : err_cmp;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prim_q <= ResetValue;
            sec_q  <= MaxVal - ResetValue;
            hit_q  <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            prim_q <= prim_d;
            sec_q  <= sec_d;
            hit_q  <= hit_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign cnt_o              = prim_q;
    assign cnt_after_commit_o = prim_nxt;
    assign thresh_hit_o       = hit_q;
    assign wrap_o             = wrap_q;
    assign err_o              = err_q;
    assign err_nxt_o          = err_d;

endmodule

// File: rtl/prim_count_bank.sv
// Bank of independent hardened cross counters sharing one combined error output.
module prim_count_bank
    import prim_count_bank_pkg::*;
#(
    parameter int unsigned      Width      = 8,
    parameter int unsigned      NumChan    = 4,
    parameter logic [Width-1:0] ResetValue = '0,
    parameter count_mode_e      Mode       = CntSaturate,
    parameter bit               ErrSticky  = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumChan-1:0]       clr_i,
    input  logic [NumChan-1:0]       set_i,
    input  logic [NumChan*Width-1:0] set_cnt_i,
    input  logic [NumChan-1:0]       incr_en_i,
    input  logic [NumChan-1:0]       decr_en_i,
    input  logic [NumChan*Width-1:0] step_i,
    input  logic [NumChan-1:0]       commit_i,
    input  logic [NumChan*Width-1:0] thresh_i,
    output logic [NumChan*Width-1:0] cnt_o,
    output logic [NumChan*Width-1:0] cnt_after_commit_o,
    output logic [NumChan-1:0]       thresh_hit_o,
    output logic [NumChan-1:0]       wrap_o,
    output logic [NumChan-1:0]       err_o,
    output logic                     err_any_o
);

    logic [NumChan-1:0] err_nxt;
    logic               err_any_q, err_any_d;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        prim_count_bank_chan #(
            .Width      (Width),
            .ResetValue (ResetValue),
            .Mode       (Mode),
            .ErrSticky  (ErrSticky)
        ) u_chan (
            .clk_i              (clk_i),
            .rst_i              (rst_i),
            .clr_i              (clr_i[c]),
            .set_i              (set_i[c]),
            .set_cnt_i          (set_cnt_i[c*Width +: Width]),
            .incr_en_i          (incr_en_i[c]),
            .decr_en_i          (decr_en_i[c]),
            .step_i             (step_i[c*Width +: Width]),
            .commit_i           (commit_i[c]),
            .thresh_i           (thresh_i[c*Width +: Width]),
            .cnt_o              (cnt_o[c*Width +: Width]),
            .cnt_after_commit_o (cnt_after_commit_o[c*Width +: Width]),
            .thresh_hit_o       (thresh_hit_o[c]),
            .wrap_o             (wrap_o[c]),
            .err_o              (err_o[c]),
            .err_nxt_o          (err_nxt[c])
        );
    end

    // Registered from the channels' next error state so it rises with err_o.
    always_comb begin
        err_any_d = |err_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_any_q <= 1'b0;
        end else begin
            err_any_q <= err_any_d;
        end
    end

    assign err_any_o = err_any_q;

endmodule

// File: tb/tb_prim_count_bank.sv
// Directed bench for prim_count_bank: a saturating and a wrapping bank driven
// by the same stimulus, checked against hand-computed values.
module tb_prim_count_bank;
    import prim_count_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  clr, set, incr, decr, commit;
    logic [31:0] set_cnt, step, thresh;

    logic [31:0] s_cnt, s_aft, w_cnt, w_aft;
    logic [3:0]  s_hit, s_wrap, s_err, w_hit, w_wrap, w_err;
    logic        s_err_any, w_err_any;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prim_count_bank #(
        .Width(8), .NumChan(4), .ResetValue(8'd5), .Mode(CntSaturate), .ErrSticky(1'b1)
    ) dut_sat (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .set_i(set), .set_cnt_i(set_cnt),
        .incr_en_i(incr), .decr_en_i(decr), .step_i(step), .commit_i(commit),
        .thresh_i(thresh), .cnt_o(s_cnt), .cnt_after_commit_o(s_aft),
        .thresh_hit_o(s_hit), .wrap_o(s_wrap), .err_o(s_err), .err_any_o(s_err_any)
    );

    prim_count_bank #(
        .Width(8), .NumChan(4), .ResetValue(8'd5), .Mode(CntWrap), .ErrSticky(1'b1)
    ) dut_wrap (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .set_i(set), .set_cnt_i(set_cnt),
        .incr_en_i(incr), .decr_en_i(decr), .step_i(step), .commit_i(commit),
        .thresh_i(thresh), .cnt_o(w_cnt), .cnt_after_commit_o(w_aft),
        .thresh_hit_o(w_hit), .wrap_o(w_wrap), .err_o(w_err), .err_any_o(w_err_any)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = '0; set = '0; incr = '0; decr = '0; commit = '0;
        set_cnt = '0; step = '0;
    endtask

    task automatic drv(input int c, input logic cl, input logic st, input logic [7:0] sv,
                       input logic inc, input logic dec, input logic [7:0] stp, input logic cm);
        clr[c] = cl; set[c] = st; set_cnt[c*8 +: 8] = sv;
        incr[c] = inc; decr[c] = dec; step[c*8 +: 8] = stp; commit[c] = cm;
    endtask

    function automatic logic [7:0] ch(input logic [31:0] v, input int c);
        return v[c*8 +: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        thresh = 32'h0A0A_0A0A;
        rst = 1'b1;
        tick();
        tick();
        check("rst_cnt_sat", s_cnt, 32'h0505_0505);
        check("rst_cnt_wrap", w_cnt, 32'h0505_0505);
        check("rst_sec", {24'h0, dut_sat.g_chan[0].u_chan.sec_q}, 32'd250);
        check("rst_pulses", {24'h0, s_hit, s_wrap}, 32'h0);
        check("rst_err", {27'h0, s_err, s_err_any}, 32'h0);
        rst = 1'b0;

        // Saturation on ch0
        drv(0, 0, 1, 8'd250, 0, 0, 8'd0, 1); tick(); idle();
        check("sat_set", ch(s_cnt, 0), 32'd250);
        drv(0, 0, 0, 8'd0, 1, 0, 8'd10, 1); #1;
        check("sat_after_commit", ch(s_aft, 0), 32'd255);
        check("wrap_after_commit", ch(w_aft, 0), 32'd4);
        tick(); idle();
        check("sat_clamp_hi", ch(s_cnt, 0), 32'd255);
        check("sat_no_wrap", {28'h0, s_wrap}, 32'h0);
        check("sat_sec_lo", {24'h0, dut_sat.g_chan[0].u_chan.sec_q}, 32'd0);
        drv(0, 0, 0, 8'd0, 1, 0, 8'd10, 1); tick(); idle();
        check("sat_hold_hi", ch(s_cnt, 0), 32'd255);
        drv(0, 0, 1, 8'd2, 0, 0, 8'd0, 1); tick();
        drv(0, 0, 0, 8'd0, 0, 1, 8'd3, 1); tick(); idle();
        check("sat_clamp_lo", ch(s_cnt, 0), 32'd0);
        check("sat_sec_hi", {24'h0, dut_sat.g_chan[0].u_chan.sec_q}, 32'd255);

        // Wrap on ch1
        drv(1, 0, 1, 8'd250, 0, 0, 8'd0, 1); tick();
        drv(1, 0, 0, 8'd0, 1, 0, 8'd10, 1); tick(); idle();
        check("wrap_cnt", ch(w_cnt, 1), 32'd4);
        check("wrap_pulse", {31'h0, w_wrap[1]}, 32'd1);
        check("wrap_no_err", {31'h0, w_err[1]}, 32'd0);
        check("wrap_sat_bank_quiet", {28'h0, s_wrap}, 32'h0);
        check("wrap_sat_bank_cnt", ch(s_cnt, 1), 32'd255);
        tick();
        check("wrap_pulse_end", {31'h0, w_wrap[1]}, 32'd0);

        // Commit gating on ch2
        drv(2, 0, 1, 8'd7, 0, 0, 8'd0, 1); tick();
        drv(2, 0, 0, 8'd0, 1, 0, 8'd1, 0); #1;
        check("gate_after_commit", ch(s_aft, 2), 32'd8);
        tick();
        check("gate_hold", ch(s_cnt, 2), 32'd7);
        commit[2] = 1'b1; tick(); idle();
        check("gate_commit", ch(s_cnt, 2), 32'd8);

        // Threshold crossing on ch3 (threshold 10)
        drv(3, 0, 1, 8'd8, 0, 0, 8'd0, 1); tick(); idle();
        check("thr_below", {31'h0, s_hit[3]}, 32'd0);
        drv(3, 0, 0, 8'd0, 1, 0, 8'd3, 1); tick(); idle();
        check("thr_cross_cnt", ch(s_cnt, 3), 32'd11);
        check("thr_cross", {31'h0, s_hit[3]}, 32'd1);
        tick();
        check("thr_one_cycle", {31'h0, s_hit[3]}, 32'd0);
        drv(3, 0, 0, 8'd0, 1, 0, 8'd3, 1); tick(); idle();
        check("thr_above_cnt", ch(s_cnt, 3), 32'd14);
        check("thr_above", {31'h0, s_hit[3]}, 32'd0);
        drv(3, 1, 0, 8'd0, 0, 0, 8'd0, 1); tick(); idle();
        check("thr_clr_cnt", ch(s_cnt, 3), 32'd5);
        check("thr_clr", {31'h0, s_hit[3]}, 32'd0);
        drv(3, 0, 1, 8'd12, 0, 0, 8'd0, 1); tick(); idle();
        check("thr_set_cross", {31'h0, s_hit[3]}, 32'd1);

        // Integrity fault on ch0 of the saturating bank
        drv(0, 0, 1, 8'd100, 0, 0, 8'd0, 1); tick(); idle();
        check("flt_pre_err", {27'h0, s_err, s_err_any}, 32'h0);
        force dut_sat.g_chan[0].u_chan.sec_q = 8'd156;
        tick();
        check("flt_err", {31'h0, s_err[0]}, 32'd1);
        check("flt_err_any", {31'h0, s_err_any}, 32'd1);
        check("flt_other_ch", {29'h0, s_err[3:1]}, 32'h0);
        release dut_sat.g_chan[0].u_chan.sec_q;
        drv(0, 1, 0, 8'd0, 0, 0, 8'd0, 1); tick(); idle();
        check("flt_clr_cnt", ch(s_cnt, 0), 32'd5);
        check("flt_sticky", {30'h0, s_err[0], s_err_any}, 32'h3);
        tick();
        check("flt_sticky2", {30'h0, s_err[0], s_err_any}, 32'h3);
        check("flt_wrap_bank_clean", {27'h0, w_err, w_err_any}, 32'h0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("flt_rst_err", {27'h0, s_err, s_err_any}, 32'h0);
        check("flt_rst_cnt", s_cnt, 32'h0505_0505);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
